// File: rtl/dma_mem_onchip_burst_ram.sv
// On-chip Avalon-MM burst RAM: byte-lane writes, incrementing read bursts with 2-cycle latency.
// Define ONCHIP_MEM_PARITY_EN to store an even-parity bit per byte and add the parity_err output.
module dma_mem_onchip_burst_ram #(
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 18,
    parameter int    DEPTH     = 196608,
    parameter int    MAX_BURST = 8,
    parameter string INIT_FILE = "dma_mem_onchip_burst_ram.hex",
    localparam int   BURST_W   = $clog2(MAX_BURST) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reset_req,
    input  logic                  clken,
    input  logic                  chipselect,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  read,
    input  logic                  write,
    input  logic [BURST_W-1:0]    burstcount,
    input  logic [DATA_W-1:0]     writedata,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest
`ifdef ONCHIP_MEM_PARITY_EN
    ,
    output logic                  parity_err
`endif
);
    localparam int NLANES = DATA_W / 8;
`ifdef ONCHIP_MEM_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [BURST_W-1:0] MAX_BEATS = BURST_W'(MAX_BURST);
    localparam logic [BURST_W-1:0] ONE_BEAT  = BURST_W'(1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                          state_q, state_d;
    logic [BURST_W-1:0]              remaining_q, remaining_d;
    logic [ADDR_W-1:0]               next_addr_q, next_addr_d;
    logic                            active;
    logic                            wr_acc;
    logic                            rd_acc;
    logic                            issue;
    logic [ADDR_W-1:0]               issue_addr;
    logic [BURST_W-1:0]              beats;
    logic                            stage1_valid_q;
    logic [NLANES-1:0][LANE_W-1:0]   wr_word;
    logic [NLANES-1:0][LANE_W-1:0]   rd_word_q;
    logic [DATA_W-1:0]               rd_data;
    logic [DATA_W-1:0]               readdata_q;
    logic                            readdatavalid_q;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
    endfunction

    assign active      = clken & ~reset_req;
    assign waitrequest = reset | ~active | (state_q == BURST);
    assign wr_acc      = chipselect & write & ~waitrequest;
    assign rd_acc      = chipselect & read & ~write & ~waitrequest;

    always_comb begin
        if (burstcount == '0) begin
            beats = ONE_BEAT;
        end else if (burstcount > MAX_BEATS) begin
            beats = MAX_BEATS;
        end else begin
            beats = burstcount;
        end
    end

    // The first beat issues straight from the bus address; BURST only issues the tail.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        next_addr_d = next_addr_q;
        issue       = 1'b0;
        issue_addr  = address;
        case (state_q)
            IDLE: begin
                if (rd_acc) begin
                    issue = 1'b1;
                    if (beats > ONE_BEAT) begin
                        state_d     = BURST;
                        remaining_d = beats - ONE_BEAT;
                        next_addr_d = addr_inc(address);
                    end
                end
            end
            BURST: begin
                issue_addr = next_addr_q;
                if (active && !reset) begin
                    issue       = 1'b1;
                    remaining_d = remaining_q - ONE_BEAT;
                    next_addr_d = addr_inc(next_addr_q);
                    if (remaining_q == ONE_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            next_addr_q <= '0;
        end else if (active) begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            next_addr_q <= next_addr_d;
        end
    end

    // Both branches share a name so the array path is the same with or without an image.
    if (INIT_FILE != "") begin : g_ram
        (* ram_init_file = INIT_FILE *)
        logic [NLANES-1:0][LANE_W-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            for (int i = 0; i < NLANES; i++) begin
                if (wr_acc && byteenable[i]) begin
                    mem[address][i] <= wr_word[i];
                end
            end
            if (issue) begin
                rd_word_q <= mem[issue_addr];
            end
        end
    end else begin : g_ram
        logic [NLANES-1:0][LANE_W-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            for (int i = 0; i < NLANES; i++) begin
                if (wr_acc && byteenable[i]) begin
                    mem[address][i] <= wr_word[i];
                end
            end
            if (issue) begin
                rd_word_q <= mem[issue_addr];
            end
        end
    end

`ifdef ONCHIP_MEM_PARITY_EN
    logic [NLANES-1:0] lane_perr;
    logic              parity_err_q;
`endif

    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
`ifdef ONCHIP_MEM_PARITY_EN
        // Stored bit makes the 9-bit lane XOR to zero; any odd flip shows as 1.
        assign wr_word[gi]   = {^writedata[gi*8 +: 8], writedata[gi*8 +: 8]};
        assign lane_perr[gi] = ^rd_word_q[gi];
`else
        assign wr_word[gi]   = writedata[gi*8 +: 8];
`endif
        assign rd_data[gi*8 +: 8] = rd_word_q[gi][7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage1_valid_q  <= 1'b0;
            readdatavalid_q <= 1'b0;
            readdata_q      <= '0;
        end else if (active) begin
            stage1_valid_q  <= issue;
            readdatavalid_q <= stage1_valid_q;
            if (stage1_valid_q) begin
                readdata_q <= rd_data;
            end
        end
    end

`ifdef ONCHIP_MEM_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else if (active) begin
            parity_err_q <= stage1_valid_q & (|lane_perr);
        end
    end
    assign parity_err = parity_err_q;
`endif

    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q;

endmodule
